seq_calc_engine: RTL
====================

// Module: seq_calc_engine
// PURPOSE
//  Clocked, handshaked responder for calculator commands: accepts {x, y, op} requests and returns a 2*WIDTH result.
//  Request and response ports use valid/ready.
//  Replaces direct combinational use of the calculator wherever a sequencer or bus bridge issues operations.
//  ADD, SUB and POW2 take one compute cycle; MUL (shift-add) and DIV (restoring) take WIDTH cycles.
// PARAMETERS
//  WIDTH   8   operand width in bits; result width is 2*WIDTH.
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  req_valid  in   1        request valid
//  req_ready  out  1        engine can accept a request (IDLE only)
//  req_x      in   WIDTH    operand x
//  req_y      in   WIDTH    operand y
//  req_op     in   3        opcode, see calc_pkg::op_e
//  res_valid  out  1        result valid
//  res_ready  in   1        consumer accepts result
//  res_data   out  2*WIDTH  result
//  res_err    out  1        error flag, qualified by res_valid
// BEHAVIOUR
//  Reset (async assert, sync deassert) forces FSM=IDLE and the following outputs:
//   req_ready=1, res_valid=0, res_data=0, res_err=0.
//  Reset mid-operation aborts the operation with no result.
//  FSM states and transitions:
//   IDLE -(req_valid & req_ready)-> CALC : operands and op are latched on that edge.
//   CALC -(cnt==last)-> DONE : last = 0 for single-cycle ops, WIDTH-1 for MUL/DIV.
//   DONE -(res_ready)-> IDLE
//  Latency: res_valid rises 2 edges after the accept edge for single-cycle ops, WIDTH+1 edges for MUL/DIV.
//  No new request is accepted while in CALC or DONE; req_ready=0 in those states.
//  res_data/res_err are held stable while res_valid=1 & res_ready=0.
//  In IDLE, res_data/res_err keep their last value and res_valid=0.
//  Opcode results:
//   000 ADD : {zeros, carry, x+y}; 0x8C+0x78 = 0x0104.
//   001 SUB : two's-complement x-y sign-extended to 2*WIDTH; 0x01-0x02 = 0xFFFF.
//   010 DIV : {remainder, quotient}.
//             y==0 -> res_data=0, res_err=1, finishes as a single-cycle op.
//   011 MUL : full unsigned 2*WIDTH product, no overflow possible.
//   100 POW2: 1<<y, x ignored.
//             y >= 2*WIDTH -> res_data=0, res_err=1.
//   101-111 : illegal -> res_data=0, res_err=1, single-cycle.
//  Arithmetic is unsigned except the SUB sign extension.
//  Iteration counter is clog2(WIDTH) bits and resets to 0 on each accept.
//  req_* inputs are ignored outside IDLE; changing them during CALC has no effect.
//  Back-to-back: the earliest next accept is the cycle after the DONE->IDLE edge.
// STRUCTURE
//  Package calc_pkg holds:
//   op_e enum: OP_ADD=0, OP_SUB=1, OP_DIV=2, OP_MUL=3, OP_POW2=4.
//   state_e enum: IDLE, CALC, DONE.
//   localparam helper CALC_W(WIDTH) = 2*WIDTH.
//  Sub-module calc_iter_unit: the shared shift-add / restoring-divide datapath.
//   Ports: start, mode, a, b, step, done, acc.
//  The top level holds the FSM, operand registers, single-cycle ops and result/error registers.
// TESTING
//  T1: ADD x=0x8C y=0x78 -> res_data=0x0104, err=0; res_valid exactly 2 edges after accept.
//  T2: SUB x=0x80 y=0x10 -> 0x0070; then x=0x01 y=0x02 -> 0xFFFF, err=0.
//  T3: MUL x=0xFF y=0xFF -> 0xFE01, res_valid at WIDTH+1=9 edges after accept.
//      Also x=0x10 y=0x04 -> 0x0040.
//  T4: DIV x=200 y=7 -> 0x041C (r=4, q=28), 9 edges.
//      Also y=0 -> 0x0000 with err=1, 2 edges.
//  T5: POW2 y=5 -> 0x0020; y=15 -> 0x8000; y=16 -> 0x0000 with err=1.
//      Op 3'b111 -> 0x0000 with err=1.
//  T6: hold res_ready=0 for 5 cycles after MUL completes -> res_data stable, req_ready=0, new req_valid ignored.
//      Pull rst_n low at cycle 4 of a MUL -> all outputs at reset values immediately, next request accepted normally.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and helpers for the sequential calculator engine.
package calc_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_DIV  = 3'd2,
    OP_MUL  = 3'd3,
    OP_POW2 = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  // Result width for a given operand width.
  function automatic int CALC_W(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/calc_iter_unit.sv
// Shared multi-cycle datapath: shift-add multiply (mode=0) and restoring divide (mode=1).
// One packed accumulator {hi, lo} serves both algorithms:
//   MUL: hi accumulates partial sums, lo holds the multiplier shifting out LSB first.
//   DIV: hi is the partial remainder, lo shifts the dividend out MSB first and the
//        quotient bits in at the bottom.
// acc presents the value after the current cycle's step, so the caller can capture
// the final result on the same edge that performs the last step.
module calc_iter_unit
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               step,
  output logic               done,
  output logic [2*WIDTH-1:0] acc
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               mode_q, mode_d;
  logic [CW-1:0]      scnt_q, scnt_d;

  logic [WIDTH-1:0]   hi, lo;
  logic [WIDTH:0]     sum, sh, diff;
  logic               ge;
  logic [2*WIDTH:0]   mul_wide;
  logic [2*WIDTH-1:0] stepped;

  // One iteration of the selected algorithm.
  always_comb begin
    hi       = acc_q[2*WIDTH-1:WIDTH];
    lo       = acc_q[WIDTH-1:0];
    sum      = {1'b0, hi} + (lo[0] ? {1'b0, opnd_q} : '0);
    mul_wide = {sum, lo} >> 1;
    sh       = {hi, lo[WIDTH-1]};
    diff     = sh - {1'b0, opnd_q};
    ge       = (sh >= {1'b0, opnd_q});
    if (mode_q) begin
      stepped = {(ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0]), ((lo << 1) | WIDTH'(ge))};
    end else begin
      stepped = mul_wide[2*WIDTH-1:0];
    end
  end

  // Load operands on start, otherwise advance one iteration per step.
  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    mode_d = mode_q;
    scnt_d = scnt_q;
    if (start) begin
      acc_d  = {{WIDTH{1'b0}}, a};
      opnd_d = b;
      mode_d = mode;
      scnt_d = '0;
    end else if (step) begin
      acc_d  = stepped;
      scnt_d = scnt_q + 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
      mode_q <= 1'b0;
      scnt_q <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      mode_q <= mode_d;
      scnt_q <= scnt_d;
    end
  end

  assign done = step && (scnt_q == CW'(WIDTH - 1));
  assign acc  = step ? stepped : acc_q;

endmodule

// File: rtl/seq_calc_engine.sv
// Handshaked calculator engine: accepts {x, y, op}, computes, returns a 2*WIDTH result.
// Single-cycle ops resolve in one CALC cycle; MUL/DIV iterate WIDTH cycles in calc_iter_unit.
module seq_calc_engine
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [WIDTH-1:0]           req_x,
  input  logic [WIDTH-1:0]           req_y,
  input  logic [2:0]                 req_op,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [CALC_W(WIDTH)-1:0]   res_data,
  output logic                       res_err
);

  localparam int RW = CALC_W(WIDTH);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [2:0]      op_q, op_d;
  logic [RW-1:0]   res_data_q, res_data_d;
  logic            res_err_q, res_err_d;

  logic            accept;
  logic            iter_op;
  logic            iter_done;
  logic [RW-1:0]   iter_acc;
  logic [CW-1:0]   last;
  logic            fin;
  logic [RW-1:0]   calc_res;
  logic            calc_err;
  logic [WIDTH:0]  add_w, sub_w;

  assign accept  = req_valid && (state_q == IDLE);
  // DIV by zero short-circuits to a single-cycle error.
  assign iter_op = (op_q == OP_MUL) || ((op_q == OP_DIV) && (y_q != '0));
  assign last    = iter_op ? CW'(WIDTH - 1) : '0;
  assign fin     = (cnt_q == last) && (!iter_op || iter_done);

  calc_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept),
    .mode  (req_op == OP_DIV),
    .a     (req_x),
    .b     (req_y),
    .step  ((state_q == CALC) && iter_op),
    .done  (iter_done),
    .acc   (iter_acc)
  );

  // Result and error for the latched op, valid on the final CALC cycle.
  always_comb begin
    calc_res = '0;
    calc_err = 1'b0;
    add_w    = {1'b0, x_q} + {1'b0, y_q};
    sub_w    = {1'b0, x_q} - {1'b0, y_q};
    case (op_q)
      OP_ADD:  calc_res = {{(WIDTH-1){1'b0}}, add_w};
      OP_SUB:  calc_res = {{(WIDTH-1){sub_w[WIDTH]}}, sub_w};
      OP_DIV:  begin
        if (y_q == '0) calc_err = 1'b1;
        else           calc_res = iter_acc;
      end
      OP_MUL:  calc_res = iter_acc;
      OP_POW2: begin
        if (int'(y_q) >= RW) calc_err = 1'b1;
        else                 calc_res = {{(RW-1){1'b0}}, 1'b1} << y_q;
      end
      default: calc_err = 1'b1;
    endcase
  end

  // FSM next state, operand capture and result capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    x_d        = x_q;
    y_d        = y_q;
    op_d       = op_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = CALC;
          x_d     = req_x;
          y_d     = req_y;
          op_d    = req_op;
          cnt_d   = '0;
        end
      end
      CALC: begin
        if (fin) begin
          state_d    = DONE;
          res_data_d = calc_res;
          res_err_d  = calc_err;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      op_q       <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      op_q       <= op_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign res_valid = (state_q == DONE);
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

endmodule
